// File: rtl/multi_digit_timer.sv
// N-digit BCD up/down timer with per-digit wrap limits, preset load,
// start/stop control and per-digit active-high 7-segment decode.
module multi_digit_timer #(
    parameter int unsigned               NUM_DIGITS   = 4,
    parameter logic [4*NUM_DIGITS-1:0]   DIGIT_LIMITS = 16'h5959
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    mode_down,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [8*NUM_DIGITS-1:0] hex_display,
    output logic                    running,
    output logic                    done,
    output logic                    carry_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [4*NUM_DIGITS-1:0]   digits_next;
    logic                      done_next;
    logic                      carry_next;
    logic                      borrow;
    logic                      carry;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 8'b11111100;
            4'd1:    seg7 = 8'b01100000;
            4'd2:    seg7 = 8'b11011010;
            4'd3:    seg7 = 8'b11110010;
            4'd4:    seg7 = 8'b01100110;
            4'd5:    seg7 = 8'b10110110;
            4'd6:    seg7 = 8'b10111110;
            4'd7:    seg7 = 8'b11100000;
            4'd8:    seg7 = 8'b11111110;
            4'd9:    seg7 = 8'b11110110;
            default: seg7 = 8'b00000010;
        endcase
    endfunction

    always_comb begin
        state_next  = state;
        digits_next = digits;
        done_next   = 1'b0;
        carry_next  = 1'b0;
        borrow      = 1'b0;
        carry       = 1'b0;
        if (load) begin
            state_next = IDLE;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (load_value[4*i +: 4] > DIGIT_LIMITS[4*i +: 4])
                    digits_next[4*i +: 4] = DIGIT_LIMITS[4*i +: 4];
                else
                    digits_next[4*i +: 4] = load_value[4*i +: 4];
            end
        end else begin
            case (state)
                IDLE: if (start) state_next = RUN;
                RUN: begin
                    if (stop) begin
                        state_next = IDLE;
                    end else if (tick) begin
                        if (mode_down) begin
                            // Zero before the tick means the countdown already expired.
                            if (digits == '0) begin
                                state_next = DONE;
                                done_next  = 1'b1;
                            end else begin
                                borrow = 1'b1;
                                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                                    if (borrow) begin
                                        if (digits_next[4*i +: 4] == 4'd0) begin
                                            digits_next[4*i +: 4] = DIGIT_LIMITS[4*i +: 4];
                                        end else begin
                                            digits_next[4*i +: 4] = digits_next[4*i +: 4] - 4'd1;
                                            borrow = 1'b0;
                                        end
                                    end
                                end
                                if (digits_next == '0) begin
                                    state_next = DONE;
                                    done_next  = 1'b1;
                                end
                            end
                        end else begin
                            carry = 1'b1;
                            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                                if (carry) begin
                                    if (digits_next[4*i +: 4] >= DIGIT_LIMITS[4*i +: 4]) begin
                                        digits_next[4*i +: 4] = 4'd0;
                                    end else begin
                                        digits_next[4*i +: 4] = digits_next[4*i +: 4] + 4'd1;
                                        carry = 1'b0;
                                    end
                                end
                            end
                            carry_next = carry;
                        end
                    end
                end
                DONE:    ;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            digits    <= '0;
            done      <= 1'b0;
            carry_out <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_next;
            digits    <= digits_next;
            done      <= done_next;
            carry_out <= carry_next;
            running   <= (state_next == RUN);
        end
    end

    always_comb begin
        hex_display = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            hex_display[8*i +: 8] = seg7(digits[4*i +: 4]);
    end

endmodule

// File: tb/tb_multi_digit_timer.sv
// Self-checking bench for multi_digit_timer: directed vector table, async
// reset sequence, and randomized traffic against a mixed-radix value model.
module tb_multi_digit_timer;

    localparam int unsigned ND  = 4;
    localparam logic [15:0] LIM = 16'h5959;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick, mode_down, start, stop, load;
    logic [15:0] load_value;
    logic [15:0] digits;
    logic [31:0] hex_display;
    logic        running, done, carry_out;

    multi_digit_timer #(.NUM_DIGITS(ND), .DIGIT_LIMITS(LIM)) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode_down(mode_down),
        .start(start), .stop(stop), .load(load), .load_value(load_value),
        .digits(digits), .hex_display(hex_display), .running(running),
        .done(done), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the timer value as a single mixed-radix integer.
    int unsigned m_val;
    int          m_state;   // 0 idle, 1 run, 2 done
    logic        m_done, m_carry;
    logic [7:0]  seg_tab [16];

    typedef struct {
        logic        ld;
        logic [15:0] lv;
        logic        st, sp, tk, md;
        logic [15:0] d;
        logic        run, dn, cy;
    } vec_t;
    vec_t vecs[$];

    function automatic int unsigned radix(input int unsigned i);
        logic [15:0] l = LIM;
        return int'(l[4*i +: 4]) + 1;
    endfunction

    function automatic int unsigned modulus();
        int unsigned m = 1;
        for (int unsigned i = 0; i < ND; i++) m *= radix(i);
        return m;
    endfunction

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] d = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            d[4*i +: 4] = 4'(v % radix(i));
            v = v / radix(i);
        end
        return d;
    endfunction

    function automatic int unsigned clamp_val(input logic [15:0] lv);
        int unsigned v = 0, w = 1, dg;
        for (int unsigned i = 0; i < ND; i++) begin
            dg = int'(lv[4*i +: 4]);
            if (dg > radix(i) - 1) dg = radix(i) - 1;
            v += dg * w;
            w *= radix(i);
        end
        return v;
    endfunction

    function automatic logic [31:0] hex_of(input logic [15:0] d);
        logic [31:0] h;
        for (int unsigned i = 0; i < ND; i++) h[8*i +: 8] = seg_tab[d[4*i +: 4]];
        return h;
    endfunction

    task automatic model_step(input logic ld, input logic [15:0] lv,
                              input logic st, input logic sp, input logic tk, input logic md);
        m_done  = 1'b0;
        m_carry = 1'b0;
        if (ld) begin
            m_val   = clamp_val(lv);
            m_state = 0;
        end else if (m_state == 0) begin
            if (st) m_state = 1;
        end else if (m_state == 1) begin
            if (sp) m_state = 0;
            else if (tk) begin
                if (md) begin
                    if (m_val != 0) m_val = m_val - 1;
                    if (m_val == 0) begin m_state = 2; m_done = 1'b1; end
                end else begin
                    m_val = m_val + 1;
                    if (m_val == modulus()) begin m_val = 0; m_carry = 1'b1; end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic ld, input logic [15:0] lv,
                        input logic st, input logic sp, input logic tk, input logic md);
        load = ld; load_value = lv; start = st; stop = sp; tick = tk; mode_down = md;
        @(posedge clk);
        #1;
        model_step(ld, lv, st, sp, tk, md);
        load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    endtask

    function automatic vec_t mk(input logic ld, input logic [15:0] lv, input logic st,
                                input logic sp, input logic tk, input logic md,
                                input logic [15:0] d, input logic run, input logic dn, input logic cy);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.tk = tk; v.md = md;
        v.d = d; v.run = run; v.dn = dn; v.cy = cy;
        return v;
    endfunction

    initial begin
        seg_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                    8'hFE, 8'hF6, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};
        //                 ld  lv        st sp tk md  digits    run dn cy
        vecs.push_back(mk(1, 16'h0003, 0, 0, 0, 1, 16'h0003, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 16'h0003, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 16'h0002, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 16'h0000, 0, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0100, 0, 0, 0, 1, 16'h0100, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 16'h0100, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 16'h0059, 1, 0, 0));
        vecs.push_back(mk(1, 16'h5958, 0, 0, 0, 0, 16'h5958, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 16'h5958, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 16'h5959, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 0));
        vecs.push_back(mk(1, 16'h7A99, 0, 0, 0, 1, 16'h5959, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 16'h5959, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 16'h5959, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 16'h5959, 1, 0, 0));
        vecs.push_back(mk(1, 16'h0042, 0, 0, 1, 1, 16'h0042, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 16'h0042, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 16'h0042, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 16'h0042, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 16'h0042, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 16'h0042, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 16'h0041, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 16'h0042, 1, 0, 0));
        vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1, 16'h0000, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 16'h0000, 0, 1, 0));

        rst = 1'b1; tick = 0; mode_down = 0; start = 0; stop = 0; load = 0; load_value = '0;
        m_val = 0; m_state = 0; m_done = 0; m_carry = 0;
        #12;
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_running", 32'(running), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_carry", 32'(carry_out), 32'h0);
        check("reset_hex", hex_display, 32'hFCFCFCFC);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            step(vecs[k].ld, vecs[k].lv, vecs[k].st, vecs[k].sp, vecs[k].tk, vecs[k].md);
            check($sformatf("vec%0d_digits", k), 32'(digits), 32'(vecs[k].d));
            check($sformatf("vec%0d_running", k), 32'(running), 32'(vecs[k].run));
            check($sformatf("vec%0d_done", k), 32'(done), 32'(vecs[k].dn));
            check($sformatf("vec%0d_carry", k), 32'(carry_out), 32'(vecs[k].cy));
            check($sformatf("vec%0d_hex", k), hex_display, hex_of(vecs[k].d));
        end

        // Asynchronous reset mid-RUN, observed before the next clock edge.
        step(1, 16'h0123, 0, 0, 0, 1);
        step(0, 16'h0000, 1, 0, 0, 1);
        check("pre_rst_digits", 32'(digits), 32'h0123);
        #3 rst = 1'b1;
        #1;
        check("async_rst_digits", 32'(digits), 32'h0);
        check("async_rst_running", 32'(running), 32'h0);
        check("async_rst_hex", hex_display, 32'hFCFCFCFC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_val = 0; m_state = 0;

        for (int n = 0; n < 800; n++) begin
            logic [15:0] lv;
            logic        ld, st, sp, tk, md;
            case ($urandom_range(0, 2))
                0:       lv = 16'($urandom);
                1:       lv = 16'h5950 | 16'($urandom_range(0, 9));
                default: lv = 16'($urandom_range(0, 12));
            endcase
            ld = ($urandom_range(0, 24) == 0);
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 15) == 0);
            tk = ($urandom_range(0, 1) == 1);
            md = ($urandom_range(0, 2) != 0);
            step(ld, lv, st, sp, tk, md);
            check("rand_digits", 32'(digits), 32'(to_bcd(m_val)));
            check("rand_running", 32'(running), 32'(m_state == 1));
            check("rand_done", 32'(done), 32'(m_done));
            check("rand_carry", 32'(carry_out), 32'(m_carry));
            check("rand_hex", hex_display, hex_of(to_bcd(m_val)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
